// File: rtl/i2c_register_sequencer_pkg.sv
// Shared encodings for the I2C register-access sequencer: FSM states,
// error codes and the helpers that describe the byte order of a transaction.
package i2c_register_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_ADDR_W = 4'd2,
    S_REG    = 4'd3,
    S_WDATA  = 4'd4,
    S_RSTART = 4'd5,
    S_ADDR_R = 4'd6,
    S_RDATA  = 4'd7,
    S_STOP   = 4'd8,
    S_FIN    = 4'd9
  } seq_state_t;

  localparam logic [1:0] I2C_ERR_NONE    = 2'b00;
  localparam logic [1:0] I2C_ERR_NACK    = 2'b01;
  localparam logic [1:0] I2C_ERR_AL      = 2'b10;
  localparam logic [1:0] I2C_ERR_TIMEOUT = 2'b11;

  // Successor of a command state when its byte completed cleanly.
  function automatic seq_state_t next_cmd_state(input seq_state_t s, input logic rnw);
    case (s)
      S_START:  return S_ADDR_W;
      S_ADDR_W: return S_REG;
      S_REG:    return rnw ? S_RSTART : S_WDATA;
      S_WDATA:  return S_STOP;
      S_RSTART: return S_ADDR_R;
      S_ADDR_R: return S_RDATA;
      S_RDATA:  return S_STOP;
      default:  return S_FIN;
    endcase
  endfunction

  // States whose command is a byte write, i.e. where the slave ACK matters.
  function automatic logic is_write_state(input seq_state_t s);
    return (s == S_ADDR_W) || (s == S_REG) || (s == S_WDATA) || (s == S_ADDR_R);
  endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Per-command watchdog: cleared when a command is issued, counts while the
// sequencer waits for the byte controller, and flags when the limit is reached.
module i2c_seq_watchdog #(
  parameter int                  TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TO_LIMIT = '1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Clear,
  input  logic En,
  output logic Expired
);

  logic [TO_WIDTH-1:0] count_reg;

  // Count wait cycles, saturating at the limit so Expired stays asserted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_reg <= '0;
    end else if (Clear) begin
      count_reg <= '0;
    end else if (En && (count_reg != TO_LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign Expired = (count_reg == TO_LIMIT);

endmodule

// File: rtl/i2c_register_sequencer.sv
// Register-access sequencer above the I2C byte controller: turns one request
// into the Start/Write/Read/Stop command sequence, checks ACKs, captures read
// data and reports completion with an error code.
module i2c_register_sequencer
  import i2c_register_sequencer_pkg::*;
#(
  parameter int                  TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(16'hFFFF)
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Req,
  input  logic       Rnw,
  input  logic [6:0] Slave_addr,
  input  logic [7:0] Reg_addr,
  input  logic [7:0] Wdata,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] Err,
  output logic [7:0] Rdata,
  output logic       Start,
  output logic       Stop,
  output logic       Read,
  output logic       Write,
  output logic       Tx_ack,
  output logic [7:0] Txd,
  input  logic       I2C_done,
  input  logic       Rx_ack,
  input  logic       I2C_al,
  input  logic [7:0] Rxd
);

  seq_state_t state_reg;
  logic       issue_reg;      // first cycle in a state: command not yet issued
  logic       rnw_reg;
  logic [6:0] slave_reg;
  logic [7:0] reg_addr_reg;
  logic [7:0] wdata_reg;
  logic       busy_reg;
  logic       done_reg;
  logic [1:0] err_reg;
  logic [7:0] rdata_reg;
  logic       start_reg;
  logic       stop_reg;
  logic       read_reg;
  logic       write_reg;
  logic [7:0] txd_reg;
  logic       wd_expired;

  // The watchdog restarts at every issue cycle and counts through the wait phase.
  i2c_seq_watchdog #(
    .TO_WIDTH (TO_WIDTH),
    .TO_LIMIT (TO_LIMIT)
  ) u_watchdog (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Clear   (issue_reg),
    .En      (busy_reg & ~issue_reg),
    .Expired (wd_expired)
  );

  // Transaction FSM with registered strobes, status and byte output.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= S_IDLE;
      issue_reg    <= 1'b1;
      rnw_reg      <= 1'b0;
      slave_reg    <= 7'h00;
      reg_addr_reg <= 8'h00;
      wdata_reg    <= 8'h00;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= I2C_ERR_NONE;
      rdata_reg    <= 8'h00;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      read_reg     <= 1'b0;
      write_reg    <= 1'b0;
      txd_reg      <= 8'h00;
    end else begin
      done_reg  <= 1'b0;
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Req) begin
            rnw_reg      <= Rnw;
            slave_reg    <= Slave_addr;
            reg_addr_reg <= Reg_addr;
            wdata_reg    <= Wdata;
            busy_reg     <= 1'b1;
            err_reg      <= I2C_ERR_NONE;
            state_reg    <= S_START;
            issue_reg    <= 1'b1;
          end
        end
        S_FIN: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
          issue_reg <= 1'b1;
        end
        default: begin
          if (I2C_al) begin
            // Bus lost: the controller no longer owns the bus, so no Stop.
            err_reg   <= I2C_ERR_AL;
            state_reg <= S_FIN;
            issue_reg <= 1'b1;
          end else if (issue_reg) begin
            issue_reg <= 1'b0;
            case (state_reg)
              S_START, S_RSTART: start_reg <= 1'b1;
              S_ADDR_W: begin
                write_reg <= 1'b1;
                txd_reg   <= {slave_reg, 1'b0};
              end
              S_REG: begin
                write_reg <= 1'b1;
                txd_reg   <= reg_addr_reg;
              end
              S_WDATA: begin
                write_reg <= 1'b1;
                txd_reg   <= wdata_reg;
              end
              S_ADDR_R: begin
                write_reg <= 1'b1;
                txd_reg   <= {slave_reg, 1'b1};
              end
              S_RDATA:  read_reg <= 1'b1;
              default:  stop_reg <= 1'b1;
            endcase
          end else if (I2C_done) begin
            issue_reg <= 1'b1;
            if (is_write_state(state_reg) && Rx_ack) begin
              // Slave NACK: skip remaining bytes and release the bus.
              err_reg   <= I2C_ERR_NACK;
              state_reg <= S_STOP;
            end else begin
              if (state_reg == S_RDATA) begin
                rdata_reg <= Rxd;
              end
              state_reg <= next_cmd_state(state_reg, rnw_reg);
            end
          end else if (wd_expired) begin
            err_reg   <= I2C_ERR_TIMEOUT;
            state_reg <= S_FIN;
            issue_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Busy   = busy_reg;
  assign Done   = done_reg;
  assign Err    = err_reg;
  assign Rdata  = rdata_reg;
  assign Start  = start_reg;
  assign Stop   = stop_reg;
  assign Read   = read_reg;
  assign Write  = write_reg;
  assign Tx_ack = 1'b1;       // single-byte reads always end with a NACK
  assign Txd    = txd_reg;

endmodule

// File: tb/tb_i2c_register_sequencer.sv
// Scoreboard bench: each request pushes the expected command/Done events,
// a monitor pops and compares them as the sequencer emits them, and a small
// byte-controller model answers the commands.
module tb_i2c_register_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Req = 1'b0;
  logic       Rnw = 1'b0;
  logic [6:0] Slave_addr = 7'h00;
  logic [7:0] Reg_addr = 8'h00;
  logic [7:0] Wdata = 8'h00;
  logic       Busy, Done, Start, Stop, Read, Write, Tx_ack;
  logic [1:0] Err;
  logic [7:0] Rdata, Txd;
  logic       I2C_done = 1'b0;
  logic       Rx_ack = 1'b0;
  logic       I2C_al = 1'b0;
  logic [7:0] Rxd = 8'h00;

  i2c_register_sequencer #(
    .TO_WIDTH (16),
    .TO_LIMIT (16'd16)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req        (Req),
    .Rnw        (Rnw),
    .Slave_addr (Slave_addr),
    .Reg_addr   (Reg_addr),
    .Wdata      (Wdata),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err),
    .Rdata      (Rdata),
    .Start      (Start),
    .Stop       (Stop),
    .Read       (Read),
    .Write      (Write),
    .Tx_ack     (Tx_ack),
    .Txd        (Txd),
    .I2C_done   (I2C_done),
    .Rx_ack     (Rx_ack),
    .I2C_al     (I2C_al),
    .Rxd        (Rxd)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event kinds: 1 Start, 2 Stop, 3 Read (data=Tx_ack), 4 Write (data=Txd), 5 Done (data={Err,Rdata})
  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  function automatic logic [31:0] ev(input logic [3:0] k, input logic [9:0] d);
    return {12'h000, k, 6'h00, d};
  endfunction

  task automatic exp_ev(input logic [3:0] k, input logic [9:0] d, input logic [9:0] dmask);
    sb_entry_t e;
    e.val  = ev(k, d);
    e.mask = {12'h000, 4'hF, 6'h00, dmask};
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input logic [31:0] got);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_event", got, 32'h0);
    end else begin
      e = sb_q.pop_front();
      check("event", got & e.mask, e.val & e.mask);
    end
  endtask

  // Monitor: compare every strobe and Done pulse against the scoreboard.
  int done_cnt = 0;
  int done_cyc = 0;
  int read_cyc = 0;
  int read_cnt = 0;
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Start === 1'b1) sb_compare(ev(4'd1, 10'h000));
      if (Stop === 1'b1)  sb_compare(ev(4'd2, 10'h000));
      if (Read === 1'b1) begin
        sb_compare(ev(4'd3, {9'h000, Tx_ack}));
        read_cyc = cyc;
        read_cnt++;
      end
      if (Write === 1'b1) sb_compare(ev(4'd4, {2'b00, Txd}));
      if (Done === 1'b1) begin
        sb_compare(ev(4'd5, {Err, Rdata}));
        $display("txn done: err=%0d rdata=%h busy=%0d cycle=%0d", Err, Rdata, Busy, cyc);
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  // Byte-controller model: completes each command two cycles after its strobe.
  logic       hang_read = 1'b0;
  logic       nack_en = 1'b0;
  logic [7:0] nack_byte = 8'h00;
  logic       al_en = 1'b0;
  logic [7:0] al_byte = 8'h00;
  logic [7:0] model_rxd = 8'h00;
  int         stop_done_cyc = 0;
  int         al_cyc = 0;
  initial begin
    logic was_write, was_stop, was_read;
    logic [7:0] byte_seen;
    forever begin
      @(negedge Clk);
      if (Rst_n && (Start === 1'b1 || Stop === 1'b1 || Read === 1'b1 || Write === 1'b1)) begin
        was_write = Write;
        was_stop  = Stop;
        was_read  = Read;
        byte_seen = Txd;
        if (was_read && hang_read) begin
          // never completes
        end else if (was_write && al_en && byte_seen == al_byte) begin
          @(negedge Clk);
          I2C_al = 1'b1;
          al_cyc = cyc;
          @(negedge Clk);
          I2C_al = 1'b0;
        end else begin
          repeat (2) @(negedge Clk);
          I2C_done = 1'b1;
          Rx_ack   = was_write && nack_en && (byte_seen == nack_byte);
          Rxd      = was_read ? model_rxd : 8'hEE;
          if (was_stop) stop_done_cyc = cyc;
          @(negedge Clk);
          I2C_done = 1'b0;
          Rx_ack   = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input logic rnw, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge Clk);
    Req = 1'b1;
    Rnw = rnw;
    Slave_addr = sa;
    Reg_addr = ra;
    Wdata = wd;
    @(negedge Clk);
    Req = 1'b0;
    check("busy_after_req", {31'h0, Busy}, 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (done_cnt == start_cnt) check("done_wait_expired", 32'h0, 32'h1);
  endtask

  task automatic exp_write_seq(input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd,
                               input logic [1:0] err);
    exp_ev(4'd1, 10'h000, 10'h000);
    exp_ev(4'd4, {2'b00, sa, 1'b0}, 10'h0FF);
    exp_ev(4'd4, {2'b00, ra}, 10'h0FF);
    exp_ev(4'd4, {2'b00, wd}, 10'h0FF);
    exp_ev(4'd2, 10'h000, 10'h000);
    exp_ev(4'd5, {err, 8'h00}, 10'h300);
  endtask

  task automatic exp_read_head(input logic [6:0] sa, input logic [7:0] ra);
    exp_ev(4'd1, 10'h000, 10'h000);
    exp_ev(4'd4, {2'b00, sa, 1'b0}, 10'h0FF);
    exp_ev(4'd4, {2'b00, ra}, 10'h0FF);
    exp_ev(4'd1, 10'h000, 10'h000);
    exp_ev(4'd4, {2'b00, sa, 1'b1}, 10'h0FF);
    exp_ev(4'd3, 10'h001, 10'h001);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},   {31'h0, Busy}, 32'h0);
    check({tag, "_done"},   {31'h0, Done}, 32'h0);
    check({tag, "_err"},    {30'h0, Err}, 32'h0);
    check({tag, "_rdata"},  {24'h0, Rdata}, 32'h0);
    check({tag, "_strobes"}, {28'h0, Start, Stop, Read, Write}, 32'h0);
    check({tag, "_tx_ack"}, {31'h0, Tx_ack}, 32'h1);
    check({tag, "_txd"},    {24'h0, Txd}, 32'h0);
  endtask

  initial begin
    int rc;
    repeat (3) @(negedge Clk);
    check_reset_values("reset");
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Register write with all bytes ACKed
    exp_write_seq(7'h50, 8'h10, 8'hA5, 2'b00);
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done(200);
    check("write_stop_to_done", done_cyc - stop_done_cyc, 32'd2);
    check("write_busy_low_with_done", {31'h0, Busy}, 32'h0);

    // Register read returning 3C
    model_rxd = 8'h3C;
    exp_read_head(7'h50, 8'h22);
    exp_ev(4'd2, 10'h000, 10'h000);
    exp_ev(4'd5, {2'b00, 8'h3C}, 10'h3FF);
    do_req(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done(200);
    check("read_stop_to_done", done_cyc - stop_done_cyc, 32'd2);

    // NACK on the address byte: Stop next, no further writes
    nack_en = 1'b1;
    nack_byte = 8'hA0;
    exp_ev(4'd1, 10'h000, 10'h000);
    exp_ev(4'd4, 10'h0A0, 10'h0FF);
    exp_ev(4'd2, 10'h000, 10'h000);
    exp_ev(4'd5, {2'b01, 8'h00}, 10'h300);
    do_req(1'b0, 7'h50, 8'h10, 8'h77);
    wait_done(200);
    nack_en = 1'b0;

    // Arbitration lost while waiting on the register byte
    al_en = 1'b1;
    al_byte = 8'h10;
    exp_ev(4'd1, 10'h000, 10'h000);
    exp_ev(4'd4, 10'h0A0, 10'h0FF);
    exp_ev(4'd4, 10'h010, 10'h0FF);
    exp_ev(4'd5, {2'b10, 8'h00}, 10'h300);
    do_req(1'b0, 7'h50, 8'h10, 8'h99);
    wait_done(200);
    check("al_to_done", done_cyc - al_cyc, 32'd2);
    al_en = 1'b0;
    // Immediately following request is accepted
    exp_write_seq(7'h51, 8'h33, 8'h5A, 2'b00);
    do_req(1'b0, 7'h51, 8'h33, 8'h5A);
    wait_done(200);

    // Read never completes: watchdog timeout, no Stop
    hang_read = 1'b1;
    exp_read_head(7'h50, 8'h22);
    exp_ev(4'd5, {2'b11, 8'h00}, 10'h300);
    do_req(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done(300);
    check("timeout_read_to_done", done_cyc - read_cyc, 32'd18);

    // Request while busy is ignored, then reset during the read wait
    exp_read_head(7'h48, 8'h05);
    rc = read_cnt;
    do_req(1'b1, 7'h48, 8'h05, 8'h00);
    repeat (2) @(negedge Clk);
    Req = 1'b1;
    Rnw = 1'b0;
    Slave_addr = 7'h11;
    Reg_addr = 8'h22;
    Wdata = 8'h33;
    @(negedge Clk);
    Req = 1'b0;
    for (int n = 0; n < 200 && read_cnt == rc; n++) @(negedge Clk);
    check("midread_reached_read", {31'h0, read_cnt != rc}, 32'h1);
    repeat (4) @(negedge Clk);
    check("midread_busy", {31'h0, Busy}, 32'h1);
    #1 Rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    hang_read = 1'b0;
    check("scoreboard_after_reset", sb_q.size(), 32'h0);

    // Clean transaction after reset
    exp_write_seq(7'h2A, 8'h01, 8'hC3, 2'b00);
    do_req(1'b0, 7'h2A, 8'h01, 8'hC3);
    wait_done(200);

    repeat (5) @(negedge Clk);
    check("scoreboard_empty", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
